// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word and round-index types, FSM
// encoding and the key-expansion round constants.
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  round_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Round constant for the word that starts round r (1..10); zero elsewhere.
  function automatic logic [7:0] rcon(input round_t r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 256-entry byte substitution.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  // Entry 0 sits in the most significant byte, entry 255 in the least.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX_TABLE[2047 - 8*int'(value) -: 8];

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: loads a cipher key and streams round
// keys 0..10 over valid/ready, computing the next key from the registered
// current key on every accepted beat.
module key_schedule_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready
);

  if (NUM_ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("key_schedule_iter: NUM_ROUNDS must be %0d", AES_ROUNDS);
  end

  localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);

  state_t state, state_nxt;
  logic   load_en, step_en;

  word_t  w0, w1, w2, w3;
  word_t  rot_w, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  round_t next_round;

  // Next round key, derived only from the registered current key.
  assign {w0, w1, w2, w3} = rk_out;
  assign rot_w      = {w3[23:0], w3[31:24]};
  assign next_round = rk_round + 4'd1;

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .value (rot_w[8*i +: 8]),
      .subst (sub_w[8*i +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon(next_round), 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign busy     = (state == EMIT);
  assign rk_valid = (state == EMIT);
  assign rk_last  = rk_valid && (rk_round == LAST_ROUND);

  // Next-state and datapath enables: load from IDLE, step or finish on a beat in EMIT.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    load_en   = 1'b0;
    step_en   = 1'b0;
    case (state)
      IDLE: begin
        if (key_load) begin
          load_en   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rk_round == LAST_ROUND) begin
            state_nxt = IDLE;
          end else begin
            step_en = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round key and index registers: load, advance on a beat, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: the key register is reset (not left unknown) because rk_out must read zero after reset.
    if (rst) begin
      rk_out   <= '0;
      rk_round <= '0;
    end else if (load_en) begin
      rk_out   <= key_in;
      rk_round <= '0;
    end else if (step_en) begin
      rk_out   <= {n0, n1, n2, n3};
      rk_round <= next_round;
    end
  end

endmodule

// File: tb/tb_key_schedule_iter.sv
// Self-checking bench for key_schedule_iter against a word-level FIPS-197
// key expansion model with an S-box derived from GF(2^8) arithmetic.
module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk   [11];
  logic [127:0] obs_rk   [11];
  int           last_beat_cycles;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  key_schedule_iter #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_load (key_load),
    .busy     (busy),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(a, 8'(i)) == 8'h01) return 8'(i);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = ginv(8'(x));
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // Full 44-word expansion; round key r is words 4r..4r+3.
  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref[temp[31:24]], sbox_ref[temp[23:16]],
                sbox_ref[temp[15:8]],  sbox_ref[temp[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; key_load = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
      n_fails++;
      $display("FAIL reset: busy=%b valid=%b out=%h round=%0d last=%b, want all zero",
               busy, rk_valid, rk_out, rk_round, rk_last);
    end
    rst = 1'b0; key_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, rk_valid);
    end
  endtask

  // Loads a key and takes all 11 beats, checking each against the model.
  task automatic test_stream(input logic [127:0] key, input bit random_ready, input string tag);
    int           idx = 0;
    int           cyc = 0;
    bit           stalled = 1'b0;
    logic [127:0] prev_out = '0;
    logic [3:0]   prev_round = '0;
    model_expand(key);
    key_in = key; key_load = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    key_load = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    while (idx < 11 && cyc < 400) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(idx) || rk_out !== exp_rk[idx] || rk_last !== (idx == 10)) begin
        n_fails++;
        $display("FAIL stream_%s r%0d: valid=%b round=%0d out=%h last=%b, want 1 %0d %h %b",
                 tag, idx, rk_valid, rk_round, rk_out, rk_last, idx, exp_rk[idx], (idx == 10));
      end
      if (stalled) begin
        n_checks++;
        if (rk_out !== prev_out || rk_round !== prev_round) begin
          n_fails++;
          $display("FAIL stall_%s: out=%h round=%0d changed, want %h %0d",
                   tag, rk_out, rk_round, prev_out, prev_round);
        end
      end
      obs_rk[idx] = rk_out;
      rk_ready    = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled     = !rk_ready;
      prev_out    = rk_out;
      prev_round  = rk_round;
      if (rk_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b0;
    last_beat_cycles = cyc;
    n_checks++;
    if (idx != 11) begin
      n_fails++;
      $display("FAIL beats_%s: got %0d beats before timeout, want 11", tag, idx);
    end
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL done_%s: busy=%b valid=%b, want 0 0", tag, busy, rk_valid);
    end
  endtask

  task automatic test_known_vector();
    test_stream(FIPS_KEY, 1'b0, "fips");
    n_checks++;
    if (obs_rk[0] !== FIPS_KEY || obs_rk[1] !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605 ||
        obs_rk[2] !== 128'hf2c295f2_7a96b943_5935807a_7359f67f ||
        obs_rk[10] !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin
      n_fails++;
      $display("FAIL fips_vectors: r0=%h r1=%h r2=%h r10=%h", obs_rk[0], obs_rk[1], obs_rk[2], obs_rk[10]);
    end
    n_checks++;
    if (last_beat_cycles != 11) begin
      n_fails++;
      $display("FAIL fips_back_to_back: %0d cycles for 11 beats, want 11", last_beat_cycles);
    end
  endtask

  task automatic test_random_stall();
    logic [127:0] ref_seq [11];
    for (int r = 0; r < 11; r++) ref_seq[r] = obs_rk[r];
    test_stream(FIPS_KEY, 1'b1, "stall");
    for (int r = 0; r < 11; r++) begin
      n_checks++;
      if (obs_rk[r] !== ref_seq[r]) begin
        n_fails++;
        $display("FAIL stall_seq r%0d: %h, want %h", r, obs_rk[r], ref_seq[r]);
      end
    end
  endtask

  task automatic test_zero_key();
    test_stream(128'h0, 1'b0, "zero");
    n_checks++;
    if (obs_rk[1] !== 128'h62636363_62636363_62636363_62636363 ||
        obs_rk[10] !== 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e) begin
      n_fails++;
      $display("FAIL zero_vectors: r1=%h r10=%h", obs_rk[1], obs_rk[10]);
    end
  endtask

  task automatic test_random_keys();
    for (int k = 0; k < 4; k++) begin
      test_stream({$urandom, $urandom, $urandom, $urandom}, 1'b1, "rand");
    end
  endtask

  task automatic test_load_ignored();
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = ~k1;
    int           n;
    model_expand(k1);
    key_in = k1; key_load = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    for (int idx = 0; idx < 11; idx++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(idx) || rk_out !== exp_rk[idx]) begin
        n_fails++;
        $display("FAIL ignore_load r%0d: valid=%b round=%0d out=%h, want 1 %0d %h",
                 idx, rk_valid, rk_round, rk_out, idx, exp_rk[idx]);
      end
      key_load = (idx == 4 || idx == 10);
      key_in   = k2;
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL ignore_done: busy=%b valid=%b, want 0 0", busy, rk_valid);
    end
    key_load = 1'b1; key_in = k2;
    @(negedge clk);
    key_load = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_out !== k2) begin
      n_fails++;
      $display("FAIL reload: valid=%b round=%0d out=%h, want 1 0 %h", rk_valid, rk_round, rk_out, k2);
    end
    n = 0;
    while (rk_valid === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rk_ready = 1'b0;
    n_checks++;
    if (n != 11) begin
      n_fails++;
      $display("FAIL reload_drain: %0d beats, want 11", n);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    int           n = 0;
    key_in = k; key_load = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    while (rk_round !== 4'd6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd6) begin
      n_fails++;
      $display("FAIL reset_mid_reach: valid=%b round=%0d, want 1 6", rk_valid, rk_round);
    end
    rst = 1'b1; key_load = 1'b1; key_in = ~k;
    @(negedge clk);
    rst = 1'b0; key_load = 1'b0; rk_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_round !== 4'd0) begin
      n_fails++;
      $display("FAIL reset_mid: busy=%b valid=%b out=%h round=%0d, want 0 0 0 0",
               busy, rk_valid, rk_out, rk_round);
    end
    test_stream(k, 1'b1, "after_rst");
  endtask

  task automatic test_load_held();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    bit           want_valid;
    int           want_round;
    model_expand(k);
    key_in = k; key_load = 1'b1; rk_ready = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 24) key_load = 1'b0;
      want_valid = (c % 12) != 0;
      want_round = (c % 12) - 1;
      n_checks++;
      if (rk_valid !== want_valid ||
          (want_valid && (rk_round !== 4'(want_round) || rk_out !== exp_rk[want_round]))) begin
        n_fails++;
        $display("FAIL load_held c%0d: valid=%b round=%0d out=%h, want valid=%b round=%0d",
                 c, rk_valid, rk_round, rk_out, want_valid, want_round);
      end
    end
    rk_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL load_held_stop: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_known_vector();
    test_random_stall();
    test_zero_key();
    test_random_keys();
    test_load_ignored();
    test_reset_mid();
    test_load_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
